// File: rtl/axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_pkg : AXI burst/response encodings and FSM state types                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    // WRAP is only legal for 2, 4, 8 or 16 beat bursts.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_burst_addr : next beat word index for FIXED / INCR / WRAP bursts       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int IDX_W = 11
) (
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       len,
    input  burst_t           burst,
    output logic [IDX_W-1:0] next_addr
);

    logic [IDX_W-1:0] w_incr;
    logic [IDX_W-1:0] w_mask;

    assign w_incr = addr + IDX_W'(1);
    assign w_mask = IDX_W'(len);

    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = w_incr;
            BURST_WRAP: begin
                // Low bits roll over inside the aligned block, high bits held.
                if (wrap_len_ok(len)) begin
                    next_addr = (addr & ~w_mask) | (w_incr & w_mask);
                end else begin
                    next_addr = w_incr;
                end
            end
            default:    next_addr = addr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_mem_rw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_mem_rw : AXI slave memory with independent burst read/write paths     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axi_mem_rw
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 2048
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    axi_slv_arvalid,
    output logic                    axi_slv_arready,
    input  logic [ID_WIDTH-1:0]     axi_slv_arid,
    input  logic [ADDR_WIDTH-1:0]   axi_slv_araddr,
    input  logic [7:0]              axi_slv_arlen,
    input  logic [1:0]              axi_slv_arburst,
    output logic                    axi_slv_rvalid,
    input  logic                    axi_slv_rready,
    output logic [ID_WIDTH-1:0]     axi_slv_rid,
    output logic [DATA_WIDTH-1:0]   axi_slv_rdata,
    output logic [1:0]              axi_slv_rresp,
    output logic                    axi_slv_rlast,
    input  logic                    axi_slv_awvalid,
    output logic                    axi_slv_awready,
    input  logic [ID_WIDTH-1:0]     axi_slv_awid,
    input  logic [ADDR_WIDTH-1:0]   axi_slv_awaddr,
    input  logic [7:0]              axi_slv_awlen,
    input  logic [1:0]              axi_slv_awburst,
    input  logic                    axi_slv_wvalid,
    output logic                    axi_slv_wready,
    input  logic [DATA_WIDTH-1:0]   axi_slv_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_slv_wstrb,
    input  logic                    axi_slv_wlast,
    output logic                    axi_slv_bvalid,
    input  logic                    axi_slv_bready,
    output logic [ID_WIDTH-1:0]     axi_slv_bid,
    output logic [1:0]              axi_slv_bresp
);

    localparam int C_STRB_W = DATA_WIDTH / 8;
    localparam int C_LSB    = $clog2(C_STRB_W);
    localparam int C_IDX_W  = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Only the word-index field of each address is decoded.
    logic w_unused_addr;
    assign w_unused_addr = ^{axi_slv_araddr, axi_slv_awaddr};

    // ------------------------------------------------------------------ read
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_state_nxt;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [C_IDX_W-1:0]    w_ar_idx;
    logic [C_IDX_W-1:0]    w_rnext;
    burst_t                w_arburst;
    logic [C_IDX_W-1:0]    r_raddr;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rbeat;
    burst_t                r_rburst;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;

    assign w_arburst = burst_t'(axi_slv_arburst);
    assign w_ar_idx  = axi_slv_araddr[C_LSB +: C_IDX_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt  = r_rd_state;
        axi_slv_arready = 1'b0;
        axi_slv_rvalid  = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                axi_slv_arready = 1'b1;
                if (axi_slv_arvalid) begin
                    w_rd_state_nxt = R_BURST;
                end
            end
            R_BURST: begin
                axi_slv_rvalid = 1'b1;
                if (axi_slv_rready && r_rlast) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    assign w_ar_hs = axi_slv_arvalid && axi_slv_arready;
    assign w_r_hs  = axi_slv_rvalid && axi_slv_rready;

    axi_burst_addr #(
        .IDX_W     (C_IDX_W)
    ) u_rd_addr (
        .addr      (r_raddr),
        .len       (r_rlen),
        .burst     (r_rburst),
        .next_addr (w_rnext)
    );

    // The beat on the bus is always pre-loaded; a handshake fetches the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rbeat  <= '0;
            r_rburst <= BURST_FIXED;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= C_RESP_OKAY;
            r_rlast  <= 1'b0;
        end else if (w_ar_hs) begin
            r_raddr  <= w_ar_idx;
            r_rlen   <= axi_slv_arlen;
            r_rbeat  <= '0;
            r_rburst <= w_arburst;
            r_rid    <= axi_slv_arid;
            r_rlast  <= (axi_slv_arlen == 8'd0);
            r_rresp  <= (w_arburst == BURST_RSVD) ? C_RESP_SLVERR : C_RESP_OKAY;
            r_rdata  <= (w_arburst == BURST_RSVD) ? '0 : mem[w_ar_idx];
        end else if (w_r_hs) begin
            if (r_rlast) begin
                r_rlast <= 1'b0;
            end else begin
                r_raddr <= w_rnext;
                r_rbeat <= r_rbeat + 8'd1;
                r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                r_rdata <= (r_rburst == BURST_RSVD) ? '0 : mem[w_rnext];
            end
        end
    end

    assign axi_slv_rid   = r_rid;
    assign axi_slv_rdata = r_rdata;
    assign axi_slv_rresp = r_rresp;
    assign axi_slv_rlast = r_rlast;

    // ----------------------------------------------------------------- write
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_state_nxt;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_mem_we;
    logic                  w_wbeat_last;
    logic                  w_wlast_err;
    logic [C_IDX_W-1:0]    w_wnext;
    burst_t                w_awburst;
    logic [C_IDX_W-1:0]    r_waddr;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wbeat;
    burst_t                r_wburst;
    logic                  r_werr;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;

    assign w_awburst = burst_t'(axi_slv_awburst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt  = r_wr_state;
        axi_slv_awready = 1'b0;
        axi_slv_wready  = 1'b0;
        axi_slv_bvalid  = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                axi_slv_awready = 1'b1;
                if (axi_slv_awvalid) begin
                    w_wr_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                axi_slv_wready = 1'b1;
                if (axi_slv_wvalid && w_wbeat_last) begin
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                axi_slv_bvalid = 1'b1;
                if (axi_slv_bready) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs      = axi_slv_awvalid && axi_slv_awready;
    assign w_w_hs       = axi_slv_wvalid && axi_slv_wready;
    assign w_wbeat_last = (r_wbeat == r_wlen);
    assign w_wlast_err  = (axi_slv_wlast != w_wbeat_last);
    assign w_mem_we     = w_w_hs && (r_wburst != BURST_RSVD);

    axi_burst_addr #(
        .IDX_W     (C_IDX_W)
    ) u_wr_addr (
        .addr      (r_waddr),
        .len       (r_wlen),
        .burst     (r_wburst),
        .next_addr (w_wnext)
    );

    // Beat count comes from awlen; wlast is only cross-checked for the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wbeat  <= '0;
            r_wburst <= BURST_FIXED;
            r_werr   <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= C_RESP_OKAY;
        end else if (w_aw_hs) begin
            r_waddr  <= axi_slv_awaddr[C_LSB +: C_IDX_W];
            r_wlen   <= axi_slv_awlen;
            r_wbeat  <= '0;
            r_wburst <= w_awburst;
            r_werr   <= (w_awburst == BURST_RSVD);
            r_bid    <= axi_slv_awid;
        end else if (w_w_hs) begin
            r_waddr <= w_wnext;
            r_wbeat <= r_wbeat + 8'd1;
            r_werr  <= r_werr | w_wlast_err;
            if (w_wbeat_last) begin
                r_bresp <= (r_werr || w_wlast_err) ? C_RESP_SLVERR : C_RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < C_STRB_W; b++) begin
                if (axi_slv_wstrb[b]) begin
                    mem[r_waddr][b*8 +: 8] <= axi_slv_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign axi_slv_bid   = r_bid;
    assign axi_slv_bresp = r_bresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_rw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_mem_rw : directed self-checking bench for axi_mem_rw                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_axi_mem_rw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    axi_mem_rw u_dut (
        .clk             (clk),
        .rst             (rst),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_arburst (arburst),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast),
        .axi_slv_awvalid (awvalid),
        .axi_slv_awready (awready),
        .axi_slv_awid    (awid),
        .axi_slv_awaddr  (awaddr),
        .axi_slv_awlen   (awlen),
        .axi_slv_awburst (awburst),
        .axi_slv_wvalid  (wvalid),
        .axi_slv_wready  (wready),
        .axi_slv_wdata   (wdata),
        .axi_slv_wstrb   (wstrb),
        .axi_slv_wlast   (wlast),
        .axi_slv_bvalid  (bvalid),
        .axi_slv_bready  (bready),
        .axi_slv_bid     (bid),
        .axi_slv_bresp   (bresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_beat(input int i, input logic [31:0] d, input logic [3:0] s, input logic l);
        wd[i] = d;
        ws[i] = s;
        wl[i] = l;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] id);
        int k;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst; awid = id;
        k = 0;
        while (!awready && k < 50) begin @(negedge clk); k++; end
        chk("awready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
            k = 0;
            while (!wready && k < 50) begin @(negedge clk); k++; end
            chk("wready", wready, 1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        k = 0;
        while (!bvalid && k < 50) begin @(negedge clk); k++; end
        chk("bvalid", bvalid, 1);
        b_resp = bresp;
        b_id   = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Beats must arrive back to back straight after the AR handshake.
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] id);
        int k;
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arid = id;
        rready = 1'b1;
        k = 0;
        while (!arready && k < 50) begin @(negedge clk); k++; end
        chk("arready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            chk("rvalid", rvalid, 1);
            chk("rid", rid, id);
            rd_data[i] = rdata;
            rd_last[i] = rlast;
            rd_resp[i] = rresp;
            @(negedge clk);
        end
        rready = 1'b0;
        chk("rvalid_after_burst", rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arburst = 0; rready = 0;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;

        repeat (2) @(negedge clk);
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_bid", bid, 0);
        rst = 1'b0;

        // Preload words 4..7 with A0..A3
        for (int i = 0; i < 4; i++) set_beat(i, 32'hA0 + i, 4'hF, i == 3);
        axi_write(32'h10, 8'd3, 2'b01, 4'd1);
        chk("preload_bresp", b_resp, 2'b00);

        axi_read(32'h10, 8'd3, 2'b01, 4'd2);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", rd_data[i], 32'hA0 + i);
            chk("incr_rlast", rd_last[i], i == 3);
            chk("incr_rresp", rd_resp[i], 2'b00);
        end

        // WRAP write from word 3: lands on words 3,0,1,2
        for (int i = 0; i < 4; i++) set_beat(i, 32'hD0 + i, 4'hF, i == 3);
        axi_write(32'h0C, 8'd3, 2'b10, 4'd5);
        chk("wrap_bresp", b_resp, 2'b00);
        chk("wrap_bid", b_id, 4'd5);
        axi_read(32'h00, 8'd3, 2'b01, 4'd0);
        chk("wrap_w0", rd_data[0], 32'hD1);
        chk("wrap_w1", rd_data[1], 32'hD2);
        chk("wrap_w2", rd_data[2], 32'hD3);
        chk("wrap_w3", rd_data[3], 32'hD0);

        // Byte strobes on word 5
        set_beat(0, 32'hFFFF_FFFF, 4'hF, 1'b1);
        axi_write(32'h14, 8'd0, 2'b01, 4'd3);
        set_beat(0, 32'h1122_3344, 4'b0101, 1'b1);
        axi_write(32'h14, 8'd0, 2'b01, 4'd3);
        axi_read(32'h14, 8'd0, 2'b01, 4'd3);
        chk("strb_word5", rd_data[0], 32'hFF22_FF44);
        chk("strb_rlast", rd_last[0], 1);

        // WRAP read from word 6: words 6,7,4,5
        axi_read(32'h18, 8'd3, 2'b10, 4'd7);
        chk("wrap_rd0", rd_data[0], 32'hA2);
        chk("wrap_rd1", rd_data[1], 32'hA3);
        chk("wrap_rd2", rd_data[2], 32'hA0);
        chk("wrap_rd3", rd_data[3], 32'hFF22_FF44);

        axi_read(32'h10, 8'd2, 2'b00, 4'd1);
        for (int i = 0; i < 3; i++) chk("fixed_rd", rd_data[i], 32'hA0);

        // Early wlast: both beats still written, SLVERR
        set_beat(0, 32'h55, 4'hF, 1'b1);
        set_beat(1, 32'h66, 4'hF, 1'b1);
        axi_write(32'h40, 8'd1, 2'b01, 4'd9);
        chk("early_wlast_bresp", b_resp, 2'b10);
        chk("early_wlast_bid", b_id, 4'd9);
        axi_read(32'h40, 8'd1, 2'b01, 4'd0);
        chk("early_wlast_w16", rd_data[0], 32'h55);
        chk("early_wlast_w17", rd_data[1], 32'h66);

        axi_read(32'h40, 8'd1, 2'b11, 4'd4);
        for (int i = 0; i < 2; i++) begin
            chk("rsvd_rdata", rd_data[i], 0);
            chk("rsvd_rresp", rd_resp[i], 2'b10);
            chk("rsvd_rlast", rd_last[i], i == 1);
        end

        set_beat(0, 32'hDEAD, 4'h0, 1'b1);
        axi_write(32'h40, 8'd0, 2'b01, 4'd2);
        chk("strb0_bresp", b_resp, 2'b00);
        set_beat(0, 32'h99, 4'hF, 1'b1);
        axi_write(32'h44, 8'd0, 2'b11, 4'd2);
        chk("rsvd_w_bresp", b_resp, 2'b10);
        axi_read(32'h40, 8'd1, 2'b01, 4'd0);
        chk("strb0_w16", rd_data[0], 32'h55);
        chk("rsvd_w_w17", rd_data[1], 32'h66);

        // Back-pressure: hold rready low for 3 cycles on beat 1
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h10; arlen = 8'd3; arburst = 2'b01; arid = 4'd6;
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        chk("bp_beat0", rdata, 32'hA0);
        @(negedge clk);
        rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", rvalid, 1);
            chk("bp_hold_data", rdata, 32'hFF22_FF44);
            chk("bp_hold_last", rlast, 0);
            @(negedge clk);
        end
        chk("bp_hold_data_end", rdata, 32'hFF22_FF44);
        rready = 1'b1;
        @(negedge clk);
        chk("bp_beat2", rdata, 32'hA2);
        chk("bp_beat2_last", rlast, 0);
        @(negedge clk);
        chk("bp_beat3", rdata, 32'hA3);
        chk("bp_beat3_last", rlast, 1);
        @(negedge clk);
        rready = 1'b0;
        chk("bp_done", rvalid, 0);

        // Reset in the middle of a read burst
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h10; arlen = 8'd7; arburst = 2'b01; arid = 4'd8;
        @(negedge clk);
        arvalid = 1'b0;
        chk("mid_rvalid", rvalid, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_arready", arready, 1);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_rid", rid, 0);
        @(negedge clk);
        rst = 1'b0;
        axi_read(32'h10, 8'd0, 2'b01, 4'd3);
        chk("post_rst_rdata", rd_data[0], 32'hA0);
        chk("post_rst_rlast", rd_last[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_mem_rw.md
AXI_MEM_RW -- requirements
Module: axi_mem_rw

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (32/64/128).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have parameter MEM_DEPTH, default 2048, words of storage (power of two).
REQ-005 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have ports axi_slv_arvalid input 1 / axi_slv_arready output 1  AR handshake.
REQ-008 SHALL have ports axi_slv_arid input ID_WIDTH, axi_slv_araddr input ADDR_WIDTH  AR id/start address.
REQ-009 SHALL have ports axi_slv_arlen input 8, axi_slv_arburst input 2  beats-1, burst type.
REQ-010 SHALL have ports axi_slv_rvalid output 1 / axi_slv_rready input 1  R handshake.
REQ-011 SHALL have ports axi_slv_rid output ID_WIDTH, axi_slv_rdata output DATA_WIDTH  R id/data.
REQ-012 SHALL have ports axi_slv_rresp output 2, axi_slv_rlast output 1  R response, final beat.
REQ-013 SHALL have ports axi_slv_awvalid input 1 / axi_slv_awready output 1  AW handshake.
REQ-014 SHALL have ports axi_slv_awid input ID_WIDTH, axi_slv_awaddr input ADDR_WIDTH  AW id/address.
REQ-015 SHALL have ports axi_slv_awlen input 8, axi_slv_awburst input 2  beats-1, burst type.
REQ-016 SHALL have ports axi_slv_wvalid input 1 / axi_slv_wready output 1  W handshake.
REQ-017 SHALL have ports axi_slv_wdata input DATA_WIDTH, axi_slv_wstrb input DATA_WIDTH/8, axi_slv_wlast input 1  W data, byte enables, last flag.
REQ-018 SHALL have ports axi_slv_bvalid output 1 / axi_slv_bready input 1, axi_slv_bid output ID_WIDTH, axi_slv_bresp output 2  B response.

Function
REQ-019 SHALL map address to word index addr[LSB +: log2(MEM_DEPTH)], LSB=log2(DATA_WIDTH/8); upper bits ignored (aliasing); only full-width beats supported.
REQ-020 SHALL compute next beat address: FIXED(00) unchanged; INCR(01) +1 modulo MEM_DEPTH; WRAP(10) +1 within (len+1)-word aligned block, len not in {1,3,7,15} treated as INCR; type 11 reserved.
REQ-021 SHALL run read FSM R_IDLE -> R_BURST on AR handshake; arready=1 only in R_IDLE; R_BURST -> R_IDLE on handshake of beat with rlast.
REQ-022 SHALL register rdata: first beat valid the cycle after AR handshake; next word loaded on each R handshake; rdata/rid/rlast stable while rvalid & !rready; one beat per cycle with rready held.
REQ-023 SHALL assert rlast on beat index == len; rresp OKAY(00), or SLVERR(10) with rdata 0 for every beat of a reserved-type burst.
REQ-024 SHALL run write FSM W_IDLE -> W_DATA on AW handshake, W_DATA -> W_RESP on handshake of beat index == len, W_RESP -> W_IDLE on B handshake; awready only in W_IDLE, wready only in W_DATA, bvalid only in W_RESP.
REQ-025 SHALL write each W beat byte-wise per wstrb; wstrb=0 writes nothing; reserved-type bursts write nothing.
REQ-026 SHALL set bresp SLVERR if wlast differs from (beat index == len) on any beat or burst type reserved, else OKAY; bid = captured awid.
REQ-027 SHALL operate read and write paths independently; same-word read load and write in one cycle returns pre-write data.

Reset
REQ-028 SHALL on rst, immediately and mid-burst, force FSMs to idle, arready=1, awready=1, rvalid/rlast/wready/bvalid=0, rdata/rid/rresp/bid/bresp=0; memory contents not reset; in-flight bursts abandoned.

Structure
REQ-029 SHALL place burst-type and response encodings (FIXED/INCR/WRAP, OKAY/SLVERR) in shared package axi_pkg.
REQ-030 SHALL instantiate one sub-module axi_burst_addr (next-address calc) twice, once per path.

Verification
REQ-031 INCR read, araddr 0x10, arlen 3, words 4..7 preloaded 0xA0..0xA3, rready=1 -> rdata A0,A1,A2,A3 on 4 consecutive cycles, rlast on 4th, rresp 00.
REQ-032 WRAP write awaddr 0x0C, awlen 3, data D0..D3 -> words 3,0,1,2 written; bresp 00, bid = awid.
REQ-033 Write word 5 = 0xFFFFFFFF, then wstrb 4'b0101 data 0x11223344 -> read word 5 = 0xFF22FF44.
REQ-034 awlen 1 with wlast on beat 0 -> both beats written, bresp 10; arburst 11 arlen 1 -> 2 beats rdata 0, rresp 10.
REQ-035 rready low 3 cycles mid-burst -> rdata/rlast unchanged; rst asserted mid read burst -> rvalid 0 same cycle, arready 1, next AR accepted normally.
